access_controller_gen: RTL and testbench
========================================

ACCESS_CONTROLLER_GEN -- requirements
Module: access_controller_gen

Interface
REQ-001 Parameter NUM_USERS, default 6, number of credential table entries searched (1..64).
REQ-002 Parameter ID_DIGITS, default 4, hex digits per user ID.
REQ-003 Parameter PASS_DIGITS, default 5, hex digits per password.
REQ-004 Parameter ROM_LAT, default 2, clock cycles from rom_addr change to valid rom data.
REQ-005 Parameter MAX_FAILS, default 3, consecutive failed attempts before lockout.
REQ-006 Parameter LOCK_CYCLES, default 1000, lockout duration in clocks.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 digit_in  in  4  hex digit from switches.
REQ-010 digit_valid  in  1  one-cycle pulse from conditioned access button; accept digit_in.
REQ-011 logout  in  1  one-cycle pulse; ends granted session.
REQ-012 reel_in, start_in  in  1 each  game buttons, ungated.
REQ-013 rom_addr  out  6  credential table address.
REQ-014 rom_id  in  4*ID_DIGITS  user ID at rom_addr.
REQ-015 rom_pass  in  4*PASS_DIGITS  password at rom_addr.
REQ-016 granted  out  1  access granted.
REQ-017 user_id  out  6  matched table index.
REQ-018 reel_out, start_out  out  1 each  game buttons gated by granted, registered.
REQ-019 phase  out  3  current state code for display decoder.
REQ-020 digit_idx  out  4  index of next digit expected in current entry.
REQ-021 digit_echo  out  4  registered copy of digit_in for display.
REQ-022 locked  out  1  lockout active.
REQ-023 fail_cnt  out  3  consecutive failures.

Function
REQ-024 States SHALL be ID_ENTRY, ID_SEARCH, PASS_ENTRY, PASS_CHECK, GRANTED, LOCKOUT.
REQ-025 In ID_ENTRY/PASS_ENTRY each digit_valid SHALL shift digit_in into the entry register, first digit ending in the most-significant nibble, and increment digit_idx.
REQ-026 Accepting digit ID_DIGITS (resp. PASS_DIGITS) SHALL move to ID_SEARCH (resp. PASS_CHECK) next cycle with digit_idx cleared.
REQ-027 digit_valid SHALL be ignored in ID_SEARCH, PASS_CHECK, GRANTED, LOCKOUT.
REQ-028 ID_SEARCH SHALL drive addresses 0..NUM_USERS-1 in order, comparing rom_id exactly ROM_LAT cycles after each address is driven; search takes at most NUM_USERS*(ROM_LAT+1) cycles.
REQ-029 First match SHALL latch user_id, stop search, enter PASS_ENTRY.
REQ-030 No match SHALL increment fail_cnt and return to ID_ENTRY.
REQ-031 PASS_CHECK SHALL drive rom_addr=user_id, compare rom_pass after ROM_LAT cycles; match -> GRANTED with fail_cnt cleared; mismatch -> fail_cnt+1, back to PASS_ENTRY.
REQ-032 fail_cnt reaching MAX_FAILS SHALL enter LOCKOUT (locked=1) for LOCK_CYCLES clocks, then ID_ENTRY with fail_cnt=0 and entry registers cleared.
REQ-033 In GRANTED granted=1 and reel_out/start_out SHALL follow inputs one cycle later; elsewhere they SHALL be 0.
REQ-034 logout in GRANTED SHALL clear granted, user_id, gated outputs and return to ID_ENTRY next cycle; logout elsewhere ignored.
REQ-035 digit_echo SHALL track digit_in with one-cycle latency in all states.
REQ-036 fail_cnt SHALL saturate at MAX_FAILS.

Reset
REQ-037 rst SHALL immediately force state ID_ENTRY and all outputs, counters, entry registers to 0, including mid-search or mid-lockout.

Structure
REQ-038 Shared package SHALL hold state encoding (phase codes) and parameter defaults.
REQ-039 One sub-module digit_accumulator (parametrised width, shift/clear/count) SHALL be instantiated for ID and password entry.

Verification
REQ-040 Table entry 0 ID 1-1-2-7, pass 7-2-1-1-A: enter both -> granted=1, user_id=0, reel_in pulse appears on reel_out one cycle later.
REQ-041 ID 3-4-7-6 at index 5, ROM_LAT=2 -> PASS_ENTRY entered after 18 search cycles, user_id=5.
REQ-042 ID 9-9-9-9 unmatched -> ID_ENTRY, fail_cnt=1; three wrong passwords for valid ID -> locked=1 for 1000 clocks, then fail_cnt=0.
REQ-043 rst asserted during ID_SEARCH and during LOCKOUT -> all outputs 0 same cycle, ID_ENTRY after release.
REQ-044 logout in GRANTED -> granted=0 next cycle; digit_valid during PASS_CHECK has no effect on digit_idx.

Source files
------------

// File: rtl/access_controller_gen_pkg.sv
// access_controller_gen_pkg: phase codes, parameter defaults and the saturating failure counter helper.
package access_controller_gen_pkg;
    typedef enum logic [2:0] {
        ID_ENTRY   = 3'd0,
        ID_SEARCH  = 3'd1,
        PASS_ENTRY = 3'd2,
        PASS_CHECK = 3'd3,
        GRANTED    = 3'd4,
        LOCKOUT    = 3'd5
    } state_e;
    localparam int NUM_USERS_DEF   = 6;
    localparam int ID_DIGITS_DEF   = 4;
    localparam int PASS_DIGITS_DEF = 5;
    localparam int ROM_LAT_DEF     = 2;
    localparam int MAX_FAILS_DEF   = 3;
    localparam int LOCK_CYCLES_DEF = 1000;
    function automatic logic [2:0] sat_inc(input logic [2:0] v, input int max);
        return (int'(v) >= max) ? 3'(max) : v + 3'd1;
    endfunction
endpackage

// File: rtl/access_controller_gen_if.sv
// access_controller_gen_if: keypad, credential ROM, game-button and status signals of the access controller.
interface access_controller_gen_if #(
    parameter int ID_DIGITS   = 4,
    parameter int PASS_DIGITS = 5
);
    logic [3:0]               digit_in;
    logic                     digit_valid;
    logic                     logout;
    logic                     reel_in;
    logic                     start_in;
    logic [5:0]               rom_addr;
    logic [4*ID_DIGITS-1:0]   rom_id;
    logic [4*PASS_DIGITS-1:0] rom_pass;
    logic                     granted;
    logic [5:0]               user_id;
    logic                     reel_out;
    logic                     start_out;
    logic [2:0]               phase;
    logic [3:0]               digit_idx;
    logic [3:0]               digit_echo;
    logic                     locked;
    logic [2:0]               fail_cnt;
    modport master (
        output digit_in, digit_valid, logout, reel_in, start_in, rom_id, rom_pass,
        input  rom_addr, granted, user_id, reel_out, start_out, phase, digit_idx,
               digit_echo, locked, fail_cnt
    );
    modport slave (
        input  digit_in, digit_valid, logout, reel_in, start_in, rom_id, rom_pass,
        output rom_addr, granted, user_id, reel_out, start_out, phase, digit_idx,
               digit_echo, locked, fail_cnt
    );
endinterface

// File: rtl/access_controller_gen_digit_accumulator.sv
// access_controller_gen_digit_accumulator: shifts hex digits in MSB-first and counts them,
// wrapping the count on the last digit so the value stays available for comparison.
module access_controller_gen_digit_accumulator #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  shift_i,
    input  logic [3:0]            digit_i,
    output logic [4*DIGITS-1:0]   value_o,
    output logic [3:0]            count_o,
    output logic                  done_o
);
    localparam int VW = 4 * DIGITS;
    logic [VW-1:0] value_q;
    logic [3:0]    count_q;
    assign done_o  = shift_i && count_q == 4'(DIGITS - 1);
    assign value_o = value_q;
    assign count_o = count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else if (clr_i) begin
            value_q <= '0;
            count_q <= '0;
        end else if (shift_i) begin
            value_q <= VW'({value_q, digit_i});
            count_q <= done_o ? 4'd0 : count_q + 4'd1;
        end
    end
endmodule

// File: rtl/access_controller_gen.sv
// access_controller_gen: keypad ID/password login against a latency-ROM credential table,
// with failure counting, timed lockout and gating of the game buttons while granted.
module access_controller_gen
    import access_controller_gen_pkg::*;
#(
    parameter int NUM_USERS   = NUM_USERS_DEF,
    parameter int ID_DIGITS   = ID_DIGITS_DEF,
    parameter int PASS_DIGITS = PASS_DIGITS_DEF,
    parameter int ROM_LAT     = ROM_LAT_DEF,
    parameter int MAX_FAILS   = MAX_FAILS_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    access_controller_gen_if.slave bus_if
);
    localparam int CW = $clog2(LOCK_CYCLES + ROM_LAT + 2);
    state_e                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [5:0]               addr_q, user_q;
    logic [2:0]               fail_q, fail_d;
    logic                     granted_q, locked_q, reel_q, start_q;
    logic [3:0]               echo_q;
    logic [4*ID_DIGITS-1:0]   id_val;
    logic [4*PASS_DIGITS-1:0] pass_val;
    logic [3:0]               id_cnt, pass_cnt;
    logic                     id_shift, pass_shift, id_done, pass_done;
    logic                     lat_hit, lock_end, lock_go, grant_hold;
    assign id_shift   = state_q == ID_ENTRY && bus_if.digit_valid;
    assign pass_shift = state_q == PASS_ENTRY && bus_if.digit_valid;
    assign lat_hit    = cnt_q == CW'(ROM_LAT);
    assign lock_end   = state_q == LOCKOUT && cnt_q == CW'(LOCK_CYCLES - 1);
    assign fail_d     = sat_inc(fail_q, MAX_FAILS);
    assign lock_go    = fail_d == 3'(MAX_FAILS);
    assign grant_hold = state_q == GRANTED && !bus_if.logout;
    access_controller_gen_digit_accumulator #(.DIGITS(ID_DIGITS)) u_id_acc (
        .clk(clk), .rst(rst), .clr_i(lock_end), .shift_i(id_shift), .digit_i(bus_if.digit_in),
        .value_o(id_val), .count_o(id_cnt), .done_o(id_done)
    );
    access_controller_gen_digit_accumulator #(.DIGITS(PASS_DIGITS)) u_pass_acc (
        .clk(clk), .rst(rst), .clr_i(lock_end), .shift_i(pass_shift), .digit_i(bus_if.digit_in),
        .value_o(pass_val), .count_o(pass_cnt), .done_o(pass_done)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ID_ENTRY;
            cnt_q     <= '0;
            addr_q    <= '0;
            user_q    <= '0;
            fail_q    <= '0;
            granted_q <= 1'b0;
            locked_q  <= 1'b0;
            reel_q    <= 1'b0;
            start_q   <= 1'b0;
            echo_q    <= '0;
        end else begin
            echo_q  <= bus_if.digit_in;
            reel_q  <= grant_hold && bus_if.reel_in;
            start_q <= grant_hold && bus_if.start_in;
            case (state_q)
                ID_ENTRY: if (id_done) begin
                    state_q <= ID_SEARCH;
                    addr_q  <= '0;
                    cnt_q   <= '0;
                end
                // each address is held for ROM_LAT cycles before its data is trusted
                ID_SEARCH: if (!lat_hit) begin
                    cnt_q <= cnt_q + CW'(1);
                end else if (bus_if.rom_id == id_val) begin
                    user_q  <= addr_q;
                    state_q <= PASS_ENTRY;
                end else if (addr_q == 6'(NUM_USERS - 1)) begin
                    fail_q   <= fail_d;
                    cnt_q    <= '0;
                    locked_q <= lock_go;
                    state_q  <= lock_go ? LOCKOUT : ID_ENTRY;
                end else begin
                    addr_q <= addr_q + 6'd1;
                    cnt_q  <= '0;
                end
                PASS_ENTRY: if (pass_done) begin
                    state_q <= PASS_CHECK;
                    addr_q  <= user_q;
                    cnt_q   <= '0;
                end
                PASS_CHECK: if (!lat_hit) begin
                    cnt_q <= cnt_q + CW'(1);
                end else if (bus_if.rom_pass == pass_val) begin
                    state_q   <= GRANTED;
                    granted_q <= 1'b1;
                    fail_q    <= '0;
                end else begin
                    fail_q   <= fail_d;
                    cnt_q    <= '0;
                    locked_q <= lock_go;
                    state_q  <= lock_go ? LOCKOUT : PASS_ENTRY;
                end
                GRANTED: if (bus_if.logout) begin
                    state_q   <= ID_ENTRY;
                    granted_q <= 1'b0;
                    user_q    <= '0;
                end
                LOCKOUT: if (lock_end) begin
                    state_q  <= ID_ENTRY;
                    locked_q <= 1'b0;
                    fail_q   <= '0;
                    user_q   <= '0;
                    addr_q   <= '0;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: state_q <= ID_ENTRY;
            endcase
        end
    end
    assign bus_if.rom_addr   = addr_q;
    assign bus_if.granted    = granted_q;
    assign bus_if.user_id    = user_q;
    assign bus_if.reel_out   = reel_q;
    assign bus_if.start_out  = start_q;
    assign bus_if.phase      = state_q;
    assign bus_if.digit_idx  = state_q == PASS_ENTRY ? pass_cnt : id_cnt;
    assign bus_if.digit_echo = echo_q;
    assign bus_if.locked     = locked_q;
    assign bus_if.fail_cnt   = fail_q;
endmodule

// File: tb/tb_access_controller_gen.sv
// tb_access_controller_gen: directed login, search-timing, lockout, logout and async-reset
// scenarios against a 2-cycle-latency credential ROM model.
module tb_access_controller_gen;
    import access_controller_gen_pkg::*;
    localparam int ROM_LAT = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int n;
    logic [15:0] id_tab   [6] = '{16'h1127, 16'hAAAA, 16'hBEEF, 16'h0F0F, 16'h1127, 16'h3476};
    logic [19:0] pass_tab [6] = '{20'h7211A, 20'h11111, 20'h22222, 20'h33333, 20'h44444, 20'h12345};
    logic [5:0]  pipe [ROM_LAT];
    logic [5:0]  ra;
    access_controller_gen_if #(.ID_DIGITS(4), .PASS_DIGITS(5)) bus ();
    access_controller_gen dut (.clk(clk), .rst(rst), .bus_if(bus));
    always #5 clk = ~clk;
    always_ff @(posedge clk) begin
        pipe[0] <= bus.rom_addr;
        pipe[1] <= pipe[0];
    end
    assign ra           = pipe[ROM_LAT-1];
    assign bus.rom_id   = (ra < 6'd6) ? id_tab[ra[2:0]] : '0;
    assign bus.rom_pass = (ra < 6'd6) ? pass_tab[ra[2:0]] : '0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        bus.digit_in    = d;
        bus.digit_valid = 1'b1;
        @(negedge clk);
        bus.digit_valid = 1'b0;
    endtask
    task automatic enter(input logic [31:0] v, input int digits);
        for (int i = 0; i < digits; i++) press(v[4*(digits-1-i) +: 4]);
    endtask
    task automatic wait_phase(input logic [2:0] p, input int budget, output int cyc);
        cyc = 0;
        while (bus.phase !== p && cyc < budget) begin
            cyc++;
            @(negedge clk);
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.digit_in = 4'h0; bus.digit_valid = 1'b0; bus.logout = 1'b0;
        bus.reel_in = 1'b0; bus.start_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phase", bus.phase, ID_ENTRY);
        check("rst_granted", bus.granted, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_fail", bus.fail_cnt, 0);
        check("rst_addr", bus.rom_addr, 0);
        rst = 1'b0;
        bus.digit_in = 4'hC;
        @(negedge clk);
        check("echo", bus.digit_echo, 4'hC);
        check("echo_no_idx", bus.digit_idx, 0);
        // entry 0 login; duplicate ID at index 4 must not win
        enter(32'h112, 3);
        check("idx3", bus.digit_idx, 3);
        press(4'h7);
        check("search_phase", bus.phase, ID_SEARCH);
        check("search_idx", bus.digit_idx, 0);
        wait_phase(PASS_ENTRY, 40, n);
        check("pe0_phase", bus.phase, PASS_ENTRY);
        check("pe0_user", bus.user_id, 0);
        enter(32'h7211A, 5);
        check("pc_phase", bus.phase, PASS_CHECK);
        press(4'h5);
        check("pc_ignore_idx", bus.digit_idx, 0);
        wait_phase(GRANTED, 10, n);
        check("gr_phase", bus.phase, GRANTED);
        check("gr_granted", bus.granted, 1);
        check("gr_user", bus.user_id, 0);
        bus.reel_in = 1'b1;
        @(negedge clk);
        bus.reel_in = 1'b0;
        check("reel_follow", bus.reel_out, 1);
        check("start_idle", bus.start_out, 0);
        @(negedge clk);
        check("reel_drop", bus.reel_out, 0);
        bus.logout = 1'b1;
        @(negedge clk);
        bus.logout = 1'b0;
        check("lo_granted", bus.granted, 0);
        check("lo_phase", bus.phase, ID_ENTRY);
        // unmatched ID
        enter(32'h9999, 4);
        wait_phase(ID_ENTRY, 40, n);
        check("nomatch_phase", bus.phase, ID_ENTRY);
        check("nomatch_fail", bus.fail_cnt, 1);
        // last entry: full 6*(2+1) search
        enter(32'h3476, 4);
        wait_phase(PASS_ENTRY, 40, n);
        check("search_cycles", n, 18);
        check("pe5_user", bus.user_id, 5);
        enter(32'h12345, 5);
        wait_phase(GRANTED, 10, n);
        check("gr5_phase", bus.phase, GRANTED);
        check("gr5_fail_clr", bus.fail_cnt, 0);
        bus.logout = 1'b1;
        @(negedge clk);
        bus.logout = 1'b0;
        // three wrong passwords
        enter(32'h1127, 4);
        wait_phase(PASS_ENTRY, 40, n);
        for (int k = 1; k <= 2; k++) begin
            enter(32'h00000, 5);
            wait_phase(PASS_ENTRY, 10, n);
            check("wrong_phase", bus.phase, PASS_ENTRY);
            check("wrong_fail", bus.fail_cnt, k);
        end
        enter(32'h00000, 5);
        wait_phase(LOCKOUT, 10, n);
        check("lock_phase", bus.phase, LOCKOUT);
        check("lock_locked", bus.locked, 1);
        check("lock_fail", bus.fail_cnt, 3);
        press(4'h1);
        check("lock_ignore_idx", bus.digit_idx, 0);
        wait_phase(ID_ENTRY, 1100, n);
        check("lock_cycles", n + 2, 1000);
        check("unlock_locked", bus.locked, 0);
        check("unlock_fail", bus.fail_cnt, 0);
        // async reset mid-search
        enter(32'h9999, 4);
        repeat (7) @(negedge clk);
        check("pre_rst_addr", bus.rom_addr, 2);
        bus.digit_in = 4'hE;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rsts_phase", bus.phase, ID_ENTRY);
        check("rsts_addr", bus.rom_addr, 0);
        check("rsts_echo", bus.digit_echo, 0);
        @(negedge clk);
        rst = 1'b0;
        // async reset mid-lockout
        for (int k = 0; k < 3; k++) begin
            enter(32'h9999, 4);
            wait_phase(ID_ENTRY, 40, n);
        end
        check("relock_phase", bus.phase, LOCKOUT);
        repeat (50) @(negedge clk);
        check("relock_sat", bus.fail_cnt, 3);
        check("relock_locked", bus.locked, 1);
        rst = 1'b1;
        #1;
        check("rstl_locked", bus.locked, 0);
        check("rstl_fail", bus.fail_cnt, 0);
        check("rstl_phase", bus.phase, ID_ENTRY);
        @(negedge clk);
        rst = 1'b0;
        press(4'h7);
        check("post_rst_idx", bus.digit_idx, 1);
        check("post_rst_phase", bus.phase, ID_ENTRY);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
